fp32_to_flopoco_8_8: RTL and testbench
======================================

# fp32_to_flopoco_8_8

Pipelined converter from IEEE-754 binary32 to the FloPoCo wE=8/wF=8 internal format. The 19-bit output is {exc[1:0], sign, exponent[7:0], fraction[7:0]}, the word consumed by the `fcmplt` comparator and the other 8_8 cores. It sits on every operand path entering the FloPoCo datapath from IEEE-domain memories and streams. It has a two-stage valid/ready pipeline and sticky status flags.

## Interface
Parameters: none. The format is fixed at binary32 in and FloPoCo 8_8 out, with identical exponent bias (127) on both sides.

- `clk` in 1: sole clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `in_valid` in 1: `in_data` carries an operand.
- `in_ready` out 1: converter accepts the operand this cycle.
- `in_data` in 32: binary32 operand, {sign, exp[7:0], frac[22:0]}.
- `out_valid` out 1: `out_data` holds a converted word.
- `out_ready` in 1: consumer takes `out_data` this cycle.
- `out_data` out 19: FloPoCo 8_8 word.
- `out_inexact` out 1: the word in `out_data` was rounded (nonzero discarded bits); qualified by `out_valid`.
- `clear_flags` in 1: synchronous clear of both sticky flags.
- `sticky_inexact` out 1: set when an inexact word is handed off (out_valid & out_ready & out_inexact).
- `sticky_flush` out 1: set when a handed-off word came from a subnormal input.

## Operation
Classification of the input, where E = exp and F = frac:
- E=0xFF, F≠0: NaN. Output is exc=11, sign kept, expfrac=0.
- E=0xFF, F=0: infinity. Output is exc=10, sign kept, expfrac=0.
- E=0, F=0: zero. Output is exc=00, sign kept, expfrac=0.
- E=0, F≠0: subnormal, flushed to signed zero. Output is exc=00 and the word is marked as flushed. It is not marked inexact.
- Otherwise: normal. Output is exc=01 with rounding as below.

Rounding of normals is round-to-nearest-even:
- Kept fraction is F[22:15]. LSB = F[15], guard = F[14], sticky = |F[13:0].
- round_up = guard & (sticky | LSB). Inexact = guard | sticky.
- {E,kept} + round_up is a 16-bit add. A fraction carry increments the exponent.
- The maximum input E is 0xFE, so the result never exceeds 0xFF00. Exponent 0xFF with exc=01 is a legal FloPoCo normal: no overflow to infinity and no carry-out.

Pipeline split:
- Stage 1 registers the class, sign, {E,kept}, round_up, inexact and flush.
- Stage 2 registers the packed word after the increment.

## Timing
- Latency is 2 cycles from acceptance (in_valid & in_ready) to out_valid, when there is no backpressure.
- Throughput is 1 word per cycle.
- Stall rules:
  - s2 advances when !s2_valid | out_ready.
  - s1 advances when !s1_valid | s2 advances.
  - in_ready = s1 advances. This is a combinational path from out_ready.
- Handshake rules:
  - While out_valid=1 and out_ready=0, out_data and out_inexact hold stable.
  - in_data is sampled only on acceptance. The pipeline holds at most 2 words.
  - Order is strictly preserved.
- Flags:
  - A sticky flag sets on the handoff cycle and is visible the next cycle.
  - If clear_flags and a set event occur in the same cycle, the set wins.
- Reset values:
  - While rst is asserted, s1_valid, s2_valid, out_valid, sticky_inexact and sticky_flush are 0, and out_data and out_inexact are 0.
  - in_ready goes to 1 on the first cycle after rst deasserts.
  - Words in flight when rst asserts are dropped, with no partial output.

## Structure
- Shared package `flopoco_8_8_pkg`:
  - exc encodings EXC_ZERO=2'b00, EXC_NORMAL=2'b01, EXC_INF=2'b10, EXC_NAN=2'b11.
  - Field widths WE=8, WF=8, and word width 19.
  - A packed struct for the 19-bit word.
  - The comparator and other 8_8 cores reuse this package.
- Sub-module `fp32_rne_8` (combinational):
  - Inputs: F[22:0]. Outputs: kept[7:0], round_up, inexact.
  - It is instantiated in stage 1. Pipeline control stays in the top module.

## Test plan
- 0x3F800000 (1.0) → out_data 0x27F00, inexact=0, out_valid exactly 2 cycles after acceptance with out_ready held high.
- RNE cases:
  - 0x3F804000 (tie, LSB even) → 0x27F00, inexact=1.
  - 0x3F80C000 (tie, LSB odd) → 0x27F02, inexact=1.
- 0x7F7FFFFF → 0x2FF00 (carry into exponent 0xFF, stays normal), inexact=1, sticky_inexact=1 the next cycle.
- Special values:
  - 0xFF800000 → 0x50000.
  - 0x7FC00000 → 0x60000.
  - 0x80000001 → 0x10000 with sticky_flush=1 and sticky_inexact unchanged.
  - 0x00000000 → 0x00000.
- Backpressure: out_ready=0 while 4 back-to-back words are offered.
  - in_ready drops after 2 acceptances.
  - out_data holds the first word.
  - After out_ready=1, all 4 words emerge in order with no loss or duplication.
- Flags and reset:
  - clear_flags in the same cycle as an inexact handoff → sticky_inexact=1.
  - rst asserted with 2 words in flight → out_valid=0 immediately (asynchronous), no stale word after release, first new word latency 2.

Source files
------------

// File: rtl/flopoco_8_8_pkg.sv
// Shared definitions for the FloPoCo wE=8/wF=8 cores: exception codes, word layout, helpers.
package flopoco_8_8_pkg;

  localparam int unsigned WE     = 8;
  localparam int unsigned WF     = 8;
  localparam int unsigned WORD_W = 2 + 1 + WE + WF;

  localparam logic [1:0] EXC_ZERO   = 2'b00;
  localparam logic [1:0] EXC_NORMAL = 2'b01;
  localparam logic [1:0] EXC_INF    = 2'b10;
  localparam logic [1:0] EXC_NAN    = 2'b11;

  typedef struct packed {
    logic [1:0]    exc;
    logic          sign;
    logic [WE-1:0] exp;
    logic [WF-1:0] frac;
  } fp_8_8_t;

  // Stage-1 payload of the binary32 converter.
  typedef struct packed {
    logic [1:0]       exc;
    logic             sign;
    logic [WE+WF-1:0] expfrac;
    logic             round_up;
    logic             inexact;
    logic             flush;
  } fp32_s1_t;

  // Subnormals classify as zero; the caller flags the flush.
  function automatic logic [1:0] fp32_exc(input logic [7:0] e, input logic [22:0] f);
    logic [1:0] exc;
    if (e == 8'hFF) begin
      exc = (f != 23'd0) ? EXC_NAN : EXC_INF;
    end else if (e == 8'h00) begin
      exc = EXC_ZERO;
    end else begin
      exc = EXC_NORMAL;
    end
    return exc;
  endfunction

endpackage

// File: rtl/fp32_to_flopoco_8_8_if.sv
// Valid/ready stream bundle for the binary32 -> FloPoCo 8_8 converter.
interface fp32_to_flopoco_8_8_if;
  import flopoco_8_8_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [31:0]       in_data;
  logic              out_valid;
  logic              out_ready;
  logic [WORD_W-1:0] out_data;
  logic              out_inexact;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_inexact
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_inexact
  );

endinterface

// File: rtl/fp32_rne_8.sv
// Round-to-nearest-even of a 23-bit binary32 fraction down to 8 bits.
module fp32_rne_8 (
  input  logic [22:0] frac_i,
  output logic [7:0]  kept_o,
  output logic        round_up_o,
  output logic        inexact_o
);

  logic lsb;
  logic guard;
  logic sticky;

  always_comb begin
    kept_o     = frac_i[22:15];
    lsb        = frac_i[15];
    guard      = frac_i[14];
    sticky     = |frac_i[13:0];
    round_up_o = guard & (sticky | lsb);
    inexact_o  = guard | sticky;
  end

endmodule

// File: rtl/fp32_to_flopoco_8_8.sv
// Two-stage valid/ready converter from IEEE binary32 to FloPoCo 8_8, with sticky status flags.
module fp32_to_flopoco_8_8
  import flopoco_8_8_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  fp32_to_flopoco_8_8_if.slave  bus,
  input  logic                  clear_flags,
  output logic                  sticky_inexact,
  output logic                  sticky_flush
);

  logic     s1_valid_q, s2_valid_q;
  fp32_s1_t s1_d, s1_q;
  fp_8_8_t  s2_word_d, s2_word_q;
  logic     s2_inexact_q, s2_flush_q;
  logic     sticky_inexact_d, sticky_inexact_q;
  logic     sticky_flush_d, sticky_flush_q;

  logic        s1_adv, s2_adv, accept, handoff;
  logic [7:0]  kept;
  logic        rne_round_up, rne_inexact;
  logic [15:0] sum;

  fp32_rne_8 u_rne (
    .frac_i     (bus.in_data[22:0]),
    .kept_o     (kept),
    .round_up_o (rne_round_up),
    .inexact_o  (rne_inexact)
  );

  // in_ready is combinational from out_ready so a full pipe streams at one word per cycle.
  always_comb begin
    s2_adv  = ~s2_valid_q | bus.out_ready;
    s1_adv  = ~s1_valid_q | s2_adv;
    accept  = bus.in_valid & s1_adv & ~rst;
    handoff = s2_valid_q & bus.out_ready;
  end

  always_comb begin
    s1_d          = '0;
    s1_d.exc      = fp32_exc(bus.in_data[30:23], bus.in_data[22:0]);
    s1_d.sign     = bus.in_data[31];
    s1_d.expfrac  = {bus.in_data[30:23], kept};
    s1_d.round_up = (s1_d.exc == EXC_NORMAL) & rne_round_up;
    s1_d.inexact  = (s1_d.exc == EXC_NORMAL) & rne_inexact;
    s1_d.flush    = (bus.in_data[30:23] == 8'h00) & (|bus.in_data[22:0]);
  end

  // Fraction carry ripples into the exponent; E<=0xFE keeps the sum within 0xFF00.
  always_comb begin
    sum            = s1_q.expfrac + 16'(s1_q.round_up);
    s2_word_d      = '0;
    s2_word_d.exc  = s1_q.exc;
    s2_word_d.sign = s1_q.sign;
    if (s1_q.exc == EXC_NORMAL) begin
      {s2_word_d.exp, s2_word_d.frac} = sum;
    end
  end

  always_comb begin
    sticky_inexact_d = (sticky_inexact_q & ~clear_flags) | (handoff & s2_inexact_q);
    sticky_flush_d   = (sticky_flush_q & ~clear_flags) | (handoff & s2_flush_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_q       <= '0;
    end else begin
      if (s1_adv) s1_valid_q <= bus.in_valid;
      if (accept) s1_q <= s1_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid_q   <= 1'b0;
      s2_word_q    <= '0;
      s2_inexact_q <= 1'b0;
      s2_flush_q   <= 1'b0;
    end else if (s2_adv) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_word_q    <= s2_word_d;
        s2_inexact_q <= s1_q.inexact;
        s2_flush_q   <= s1_q.flush;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sticky_inexact_q <= 1'b0;
      sticky_flush_q   <= 1'b0;
    end else begin
      sticky_inexact_q <= sticky_inexact_d;
      sticky_flush_q   <= sticky_flush_d;
    end
  end

  assign bus.in_ready    = s1_adv & ~rst;
  assign bus.out_valid   = s2_valid_q;
  assign bus.out_data    = s2_word_q;
  assign bus.out_inexact = s2_inexact_q;
  assign sticky_inexact  = sticky_inexact_q;
  assign sticky_flush    = sticky_flush_q;

endmodule

// File: tb/tb_fp32_to_flopoco_8_8.sv
// Bench for fp32_to_flopoco_8_8: vector table through a scoreboard plus stall, flag and reset sequences.
module tb_fp32_to_flopoco_8_8;
  import flopoco_8_8_pkg::*;

  typedef struct {
    logic [31:0] din;
    logic [18:0] dout;
    logic        inx;
  } vec_t;

  typedef struct {
    logic [18:0] dout;
    logic        inx;
    bit          chk_lat;
    int          acc_cyc;
  } sb_t;

  localparam int NVEC = 17;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic clear_flags = 1'b0;
  logic sticky_inexact, sticky_flush;

  fp32_to_flopoco_8_8_if bus ();

  fp32_to_flopoco_8_8 dut (
    .clk            (clk),
    .rst            (rst),
    .bus            (bus),
    .clear_flags    (clear_flags),
    .sticky_inexact (sticky_inexact),
    .sticky_flush   (sticky_flush)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int acc_cnt = 0;
  int hand_cnt = 0;
  sb_t sb[$];
  sb_t mon_e;
  logic [18:0] exp_dout;
  logic exp_inx;
  bit lat_mode = 1'b0;
  bit drv_done = 1'b0;
  vec_t vecs[NVEC];
  vec_t bp[4];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Scoreboard: push on acceptance, pop and compare on handoff.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.out_valid && bus.out_ready) begin
        hand_cnt++;
        if (sb.size() == 0) begin
          chk("unexpected_word", {13'd0, bus.out_data}, 32'h0);
        end else begin
          mon_e = sb.pop_front();
          chk("out_data", {13'd0, bus.out_data}, {13'd0, mon_e.dout});
          chk("out_inexact", {31'd0, bus.out_inexact}, {31'd0, mon_e.inx});
          if (mon_e.chk_lat) chk("latency", cyc - mon_e.acc_cyc, 2);
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        acc_cnt++;
        sb.push_back('{dout: exp_dout, inx: exp_inx, chk_lat: lat_mode, acc_cyc: cyc});
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] d, input logic [18:0] od, input logic oi, input bit hold);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    exp_dout     = od;
    exp_inx      = oi;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.in_ready && n < 50);
    if (!bus.in_ready) chk("accept_timeout", 0, 1);
    @(posedge clk);
    #1;
    if (!hold) bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain", sb.size(), 0);
    tick(1);
  endtask

  task automatic wait_handoff();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(bus.out_valid && bus.out_ready) && n < 50);
    if (!(bus.out_valid && bus.out_ready)) chk("handoff_timeout", 0, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc0, h0, n;
    vecs[0]  = '{32'h3F800000, 19'h27F00, 1'b0};
    vecs[1]  = '{32'h3F804000, 19'h27F00, 1'b1};
    vecs[2]  = '{32'h3F80C000, 19'h27F02, 1'b1};
    vecs[3]  = '{32'h7F7FFFFF, 19'h2FF00, 1'b1};
    vecs[4]  = '{32'hFF800000, 19'h50000, 1'b0};
    vecs[5]  = '{32'h7FC00000, 19'h60000, 1'b0};
    vecs[6]  = '{32'h80000001, 19'h10000, 1'b0};
    vecs[7]  = '{32'h00000000, 19'h00000, 1'b0};
    vecs[8]  = '{32'hC0490FDB, 19'h38092, 1'b1};
    vecs[9]  = '{32'h3F80FFFF, 19'h27F02, 1'b1};
    vecs[10] = '{32'h7F800001, 19'h60000, 1'b0};
    vecs[11] = '{32'h00400000, 19'h00000, 1'b0};
    vecs[12] = '{32'h3F817FFF, 19'h27F03, 1'b1};
    vecs[13] = '{32'h40000000, 19'h28000, 1'b0};
    vecs[14] = '{32'hBF800000, 19'h37F00, 1'b0};
    vecs[15] = '{32'h3F807FFF, 19'h27F01, 1'b1};
    vecs[16] = '{32'h3F800001, 19'h27F00, 1'b1};
    bp[0] = vecs[0];
    bp[1] = vecs[2];
    bp[2] = vecs[4];
    bp[3] = vecs[5];

    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    #1 rst = 1'b1;
    tick(2);
    chk("rst_out_valid", {31'd0, bus.out_valid}, 0);
    chk("rst_out_data", {13'd0, bus.out_data}, 0);
    chk("rst_out_inexact", {31'd0, bus.out_inexact}, 0);
    chk("rst_sticky_inexact", {31'd0, sticky_inexact}, 0);
    chk("rst_sticky_flush", {31'd0, sticky_flush}, 0);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("in_ready_after_rst", {31'd0, bus.in_ready}, 1);
    tick(1);

    // Back-to-back vector stream, no backpressure, latency checked on every word.
    bus.out_ready = 1'b1;
    lat_mode = 1'b1;
    for (int i = 0; i < NVEC; i++) send(vecs[i].din, vecs[i].dout, vecs[i].inx, i != NVEC - 1);
    drain();
    lat_mode = 1'b0;
    chk("table_sticky_inexact", {31'd0, sticky_inexact}, 1);
    chk("table_sticky_flush", {31'd0, sticky_flush}, 1);

    // Flush flag alone from a subnormal.
    clear_flags = 1'b1;
    tick(1);
    clear_flags = 1'b0;
    chk("clear_inexact", {31'd0, sticky_inexact}, 0);
    chk("clear_flush", {31'd0, sticky_flush}, 0);
    send(32'h80000001, 19'h10000, 1'b0, 1'b0);
    wait_handoff();
    chk("flush_before", {31'd0, sticky_flush}, 0);
    tick(1);
    chk("flush_after", {31'd0, sticky_flush}, 1);
    chk("flush_keeps_inexact", {31'd0, sticky_inexact}, 0);
    send(32'h7F7FFFFF, 19'h2FF00, 1'b1, 1'b0);
    wait_handoff();
    chk("inexact_before", {31'd0, sticky_inexact}, 0);
    tick(1);
    chk("inexact_after", {31'd0, sticky_inexact}, 1);

    // Clear and set in the same cycle: set wins.
    clear_flags = 1'b1;
    tick(1);
    clear_flags = 1'b0;
    chk("clear2_inexact", {31'd0, sticky_inexact}, 0);
    bus.out_ready = 1'b0;
    send(32'h3F804000, 19'h27F00, 1'b1, 1'b0);
    tick(3);
    chk("parked_valid", {31'd0, bus.out_valid}, 1);
    chk("parked_inexact", {31'd0, bus.out_inexact}, 1);
    chk("parked_sticky", {31'd0, sticky_inexact}, 0);
    clear_flags   = 1'b1;
    bus.out_ready = 1'b1;
    tick(1);
    clear_flags = 1'b0;
    chk("set_beats_clear", {31'd0, sticky_inexact}, 1);

    // Backpressure: four words offered while the consumer stalls.
    bus.out_ready = 1'b0;
    acc0 = acc_cnt;
    h0 = hand_cnt;
    drv_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 4; i++) send(bp[i].din, bp[i].dout, bp[i].inx, i != 3);
        drv_done = 1'b1;
      end
    join_none
    tick(6);
    chk("bp_in_ready", {31'd0, bus.in_ready}, 0);
    chk("bp_accepted", acc_cnt - acc0, 2);
    chk("bp_out_valid", {31'd0, bus.out_valid}, 1);
    chk("bp_hold_data", {13'd0, bus.out_data}, {13'd0, bp[0].dout});
    tick(1);
    chk("bp_hold_data2", {13'd0, bus.out_data}, {13'd0, bp[0].dout});
    bus.out_ready = 1'b1;
    n = 0;
    while (!drv_done && n < 100) begin
      tick(1);
      n++;
    end
    chk("bp_driver_done", {31'd0, drv_done}, 1);
    drain();
    chk("bp_handoffs", hand_cnt - h0, 4);

    // Asynchronous reset with two words in flight.
    bus.out_ready = 1'b0;
    send(32'h3F800000, 19'h27F00, 1'b0, 1'b1);
    send(32'h3F80C000, 19'h27F02, 1'b1, 1'b0);
    #1 chk("inflight_valid", {31'd0, bus.out_valid}, 1);
    #1 rst = 1'b1;
    #1;
    chk("async_rst_valid", {31'd0, bus.out_valid}, 0);
    chk("async_rst_data", {13'd0, bus.out_data}, 0);
    sb.delete();
    tick(2);
    bus.out_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    h0 = hand_cnt;
    repeat (3) begin
      @(negedge clk);
      chk("no_stale_word", {31'd0, bus.out_valid}, 0);
    end
    tick(1);
    lat_mode = 1'b1;
    send(32'h3F800000, 19'h27F00, 1'b0, 1'b0);
    drain();
    lat_mode = 1'b0;
    chk("post_rst_handoffs", hand_cnt - h0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
